argmax_row_engine: RTL and testbench

Reads the final-layer output feature matrix one element at a time from feature memory, computes the argmax column (class index) of each row, and streams one `{row, class}` result per row to downstream logic over a valid/ready handshake. It is the read-and-decide side of the argmax stage and contains its own row and column sequencing. It is started by the top-level GCN FSM once the output feature memory is fully written, and it signals completion back to that FSM.

---
 rtl/argmax_row_engine.sv | 145 ++++++++++++++
 tb/tb_argmax_row_engine.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_row_engine.sv
// argmax_row_engine: walks the output feature matrix row by row, tracks the largest
// signed element of each row and hands {row, class} downstream over valid/ready.
module argmax_row_engine #(
  parameter int FEATURE_ROWS   = 6,
  parameter int FEATURE_COLS   = 3,
  parameter int DOT_PROD_WIDTH = 16,
  localparam int ROW_W = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  localparam int COL_W = (FEATURE_COLS > 1) ? $clog2(FEATURE_COLS) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  output logic                             rd_en,
  output logic        [ROW_W-1:0]          rd_row,
  output logic        [COL_W-1:0]          rd_col,
  input  logic signed [DOT_PROD_WIDTH-1:0] rd_data,
  output logic                             argmax_valid,
  input  logic                             argmax_ready,
  output logic        [ROW_W-1:0]          argmax_row,
  output logic        [COL_W-1:0]          argmax_idx,
  output logic                             busy,
  output logic                             done
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(FEATURE_COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic               [ROW_W-1:0]    r_row;
  logic               [ROW_W-1:0]    w_row_nxt;
  logic               [COL_W-1:0]    r_col;
  logic               [COL_W-1:0]    w_col_nxt;
  logic                              r_vld_p1;
  logic               [COL_W-1:0]    r_col_p1;
  logic signed [DOT_PROD_WIDTH-1:0]  r_best_val_p2;
  logic               [COL_W-1:0]    r_best_idx_p2;
  logic                              w_take_p1;

  // Column 0 always seeds the running maximum; later columns must be strictly
  // greater, so ties resolve to the lowest class index.
  function automatic logic f_replace(
    input logic                             is_first,
    input logic signed [DOT_PROD_WIDTH-1:0] cand,
    input logic signed [DOT_PROD_WIDTH-1:0] best
  );
    return is_first || (cand > best);
  endfunction

  // Control state: FSM, row/column counters and the read-return tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_vld_p1 <= 1'b0;
      r_col_p1 <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_vld_p1 <= rd_en;
      r_col_p1 <= rd_col;
    end
  end

  // p1 -> p2: rd_data for the read issued last cycle is compared and registered.
  assign w_take_p1 = r_vld_p1 && f_replace((r_col_p1 == '0), rd_data, r_best_val_p2);

  always_ff @(posedge clk) begin
    if (w_take_p1) begin
      r_best_val_p2 <= rd_data;
      r_best_idx_p2 <= r_col_p1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    rd_en        = 1'b0;
    rd_row       = '0;
    rd_col       = '0;
    argmax_valid = 1'b0;
    argmax_row   = '0;
    argmax_idx   = '0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_row_nxt   = '0;
          w_col_nxt   = '0;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        rd_en  = 1'b1;
        rd_row = r_row;
        rd_col = r_col;
        if (r_col == LAST_COL) begin
          w_col_nxt   = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_col_nxt = r_col + 1'b1;
        end
      end
      S_DRAIN: begin
        w_state_nxt = S_EMIT;
      end
      S_EMIT: begin
        argmax_valid = 1'b1;
        argmax_row   = r_row;
        argmax_idx   = r_best_idx_p2;
        if (argmax_ready) begin
          w_col_nxt = '0;
          if (r_row == LAST_ROW) begin
            w_row_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_row_nxt   = r_row + 1'b1;
            w_state_nxt = S_READ;
          end
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_argmax_row_engine.sv
// Bench for argmax_row_engine: feature memory model, argmax reference and a
// per-cycle compare process on the result handshake.
module tb_argmax_row_engine;

  localparam int ROWS = 6;
  localparam int COLS = 3;
  localparam int DW   = 16;

  localparam int MODE_HIGH  = 0;
  localparam int MODE_STALL = 1;
  localparam int MODE_IGN   = 2;
  localparam int MODE_RAND  = 3;

  logic                 clk;
  logic                 reset_n;
  logic                 start;
  logic                 rd_en;
  logic [2:0]           rd_row;
  logic [1:0]           rd_col;
  logic signed [DW-1:0] rd_data;
  logic                 argmax_valid;
  logic                 argmax_ready;
  logic [2:0]           argmax_row;
  logic [1:0]           argmax_idx;
  logic                 busy;
  logic                 done;

  argmax_row_engine #(
    .FEATURE_ROWS  (ROWS),
    .FEATURE_COLS  (COLS),
    .DOT_PROD_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .rd_en       (rd_en),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_data     (rd_data),
    .argmax_valid(argmax_valid),
    .argmax_ready(argmax_ready),
    .argmax_row  (argmax_row),
    .argmax_idx  (argmax_idx),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int row;
    int idx;
  } res_t;

  logic signed [DW-1:0] mem [0:ROWS-1][0:COLS-1];
  res_t exp_q[$];
  int   got_idx [0:ROWS-1];
  int   lit_idx [0:ROWS-1] = '{1, 0, 2, 0, 1, 2};
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Feature memory: one-cycle registered read.
  always @(posedge clk) begin
    if (rd_en)
      rd_data <= (int'(rd_row) < ROWS && int'(rd_col) < COLS) ? mem[rd_row][rd_col] : '0;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: first column holding the row's maximum signed value.
  function automatic int ref_argmax(input int r);
    int best;
    best = 0;
    for (int c = 1; c < COLS; c++)
      if (mem[r][c] > mem[r][best]) best = c;
    return best;
  endfunction

  task automatic build_expected();
    res_t e;
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      e.row = r;
      e.idx = ref_argmax(r);
      exp_q.push_back(e);
      got_idx[r] = -1;
    end
  endtask

  task automatic load_basic();
    int vals [0:17] = '{5, 9, 2, -1, -3, -2, 0, 0, 7, 4, 4, 4, -8, 7, 6, 1, 2, 3};
    for (int i = 0; i < 18; i++) mem[i / 3][i % 3] = 16'(vals[i]);
  endtask

  task automatic load_random(input bit narrow);
    int v;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        if (narrow) begin
          v = int'($urandom_range(0, 6)) - 3;
          mem[r][c] = 16'(v);
        end else begin
          mem[r][c] = 16'($urandom);
        end
      end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"},        int'(rd_en),        0);
    chk({tag, "_rd_row"},       int'(rd_row),       0);
    chk({tag, "_rd_col"},       int'(rd_col),       0);
    chk({tag, "_argmax_valid"}, int'(argmax_valid), 0);
    chk({tag, "_argmax_row"},   int'(argmax_row),   0);
    chk({tag, "_argmax_idx"},   int'(argmax_idx),   0);
    chk({tag, "_busy"},         int'(busy),         0);
    chk({tag, "_done"},         int'(done),         0);
  endtask

  // Compare process: every handshake against the model, hold-stability while
  // stalled, no reads while a result is presented.
  initial begin : monitor
    res_t e;
    bit   prev_hold;
    int   prev_row;
    int   prev_idx;
    prev_hold = 1'b0;
    prev_row  = 0;
    prev_idx  = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("valid_held", int'(argmax_valid), 1);
          chk("row_held",   int'(argmax_row),   prev_row);
          chk("idx_held",   int'(argmax_idx),   prev_idx);
        end
        if (argmax_valid) chk("rd_en_while_emit", int'(rd_en), 0);
        if (argmax_valid && argmax_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result_row", int'(argmax_row), -1);
          end else begin
            e = exp_q.pop_front();
            chk("result_row", int'(argmax_row), e.row);
            chk("result_idx", int'(argmax_idx), e.idx);
            if (int'(argmax_row) < ROWS) got_idx[argmax_row] = int'(argmax_idx);
          end
        end
        if (done) done_cnt++;
        prev_hold = argmax_valid && !argmax_ready;
        prev_row  = int'(argmax_row);
        prev_idx  = int'(argmax_idx);
      end
    end
  end

  // Caller is positioned 1 time unit after a rising edge; start is sampled at the
  // next edge (cycle 0) and the loop tracks the cycle label in which done appears.
  task automatic do_run(input int mode, input int exp_cycles);
    int done_at;
    int stall;
    bit pulsed;
    int k;
    build_expected();
    done_cnt = 0;
    done_at  = 0;
    stall    = 0;
    pulsed   = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 1;
    while (done_at == 0 && k <= 400) begin
      case (mode)
        MODE_STALL: begin
          if (argmax_valid && argmax_row == 3'd2 && stall < 4) begin
            argmax_ready = 1'b0;
            stall++;
          end else begin
            argmax_ready = 1'b1;
          end
        end
        MODE_RAND: argmax_ready = ($urandom_range(0, 3) != 0);
        default:   argmax_ready = 1'b1;
      endcase
      if (mode == MODE_IGN && !pulsed && rd_en && rd_row == 3'd3) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) done_at = k;
      @(posedge clk);
      #1;
      k++;
    end
    start        = 1'b0;
    argmax_ready = 1'b1;
    if (done_at == 0) chk("done_timeout", 0, 1);
    else if (exp_cycles > 0) chk("done_cycle", done_at, exp_cycles);
    if (mode == MODE_STALL) chk("stall_cycles", stall, 4);
    if (mode == MODE_IGN) chk("ignored_start_pulsed", int'(pulsed), 1);
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
    chk("results_pending", exp_q.size(), 0);
    chk("done_count", done_cnt, 1);
  endtask

  initial begin : main
    int k;
    reset_n      = 1'b0;
    start        = 1'b0;
    argmax_ready = 1'b1;
    load_basic();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic matrix, model pinned to hand-computed indices.
    for (int r = 0; r < ROWS; r++) chk("model_basic", ref_argmax(r), lit_idx[r]);
    do_run(MODE_HIGH, 31);
    for (int r = 0; r < ROWS; r++) chk("basic_idx", got_idx[r], lit_idx[r]);

    // Back-to-back: start in the IDLE cycle right after done.
    do_run(MODE_HIGH, 31);
    for (int r = 0; r < ROWS; r++) chk("rerun_idx", got_idx[r], lit_idx[r]);

    // Signed extremes and ties.
    mem[0][0] = 16'sh8000; mem[0][1] = 16'sh7FFF; mem[0][2] = 16'sh7FFF;
    mem[1][0] = -16'sd5;   mem[1][1] = -16'sd5;   mem[1][2] = -16'sd6;
    chk("model_signed", ref_argmax(0), 1);
    chk("model_tie", ref_argmax(1), 0);
    do_run(MODE_HIGH, 31);
    chk("signed_idx", got_idx[0], 1);
    chk("tie_idx", got_idx[1], 0);

    // Backpressure on row 2 adds exactly the stall length.
    load_basic();
    do_run(MODE_STALL, 35);

    // Start pulse during row 3 reads is ignored.
    do_run(MODE_IGN, 31);

    // Reset while presenting row 1.
    build_expected();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (!(argmax_valid && argmax_row == 3'd1) && k < 100) begin
      argmax_ready = 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    argmax_ready = 1'b0;
    chk("reached_emit_row1", int'(k < 100), 1);
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n      = 1'b1;
    argmax_ready = 1'b1;
    @(posedge clk);
    #1;
    do_run(MODE_HIGH, 31);

    // Randomized data and backpressure.
    for (int t = 0; t < 6; t++) begin
      load_random(t[0]);
      do_run((t < 2) ? MODE_HIGH : MODE_RAND, (t < 2) ? 31 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
